// File: rtl/cursor_pkg.sv
// Shared state encoding, default colours and width helper for the palette cursor drawer.
package cursor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ERASE = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ERASE = ST_ERASE,
        DRAW  = ST_DRAW,
        DONE  = ST_DONE
    } state_t;

    localparam logic [2:0] CURSOR_FG_DEF = 3'b111;
    localparam logic [2:0] CURSOR_BG_DEF = 3'b000;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/box_scan.sv
// Raster walk over a BOX x BOX square (ox inner, oy outer) with a look-ahead of
// the next position so the owner can register its pixel outputs.
module box_scan
    import cursor_pkg::*;
#(
    parameter int BOX = 4,
    localparam int W  = idx_w(BOX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         en,
    output logic         last,
    output logic [W-1:0] nxt_ox,
    output logic [W-1:0] nxt_oy,
    output logic         nxt_perim
);

    localparam logic [W-1:0] EDGE = W'(BOX - 1);

    logic [W-1:0] ox;
    logic [W-1:0] oy;

    assign last = (ox == EDGE) && (oy == EDGE);

    // After the last position the walk wraps back to the origin.
    always_comb begin
        nxt_ox = ox + 1'b1;
        nxt_oy = oy;
        if (ox == EDGE) begin
            nxt_ox = '0;
            nxt_oy = (oy == EDGE) ? '0 : oy + 1'b1;
        end
    end

    assign nxt_perim = (nxt_ox == '0) || (nxt_ox == EDGE) ||
                       (nxt_oy == '0) || (nxt_oy == EDGE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ox <= '0;
            oy <= '0;
        end else if (start) begin
            ox <= '0;
            oy <= '0;
        end else if (en) begin
            ox <= nxt_ox;
            oy <= nxt_oy;
        end
    end

endmodule

// File: rtl/cursor_paleta_gen.sv
// Palette cursor drawer: moves the selected cell, erases the old outline and draws the new one.
// Optional macro CURSOR_BLINK_EN adds a free-running blink that redraws the outline in FG/BG.
module cursor_paleta_gen
    import cursor_pkg::*;
#(
    parameter int                 N_COLORS     = 8,
    parameter int                 COLOR_W      = 3,
    parameter int                 COORD_W      = 5,
    parameter int                 BOX          = 4,
    parameter int                 PAL_X0       = 0,
    parameter int                 PAL_Y0       = 28,
    parameter logic [COLOR_W-1:0] CURSOR_FG    = COLOR_W'(CURSOR_FG_DEF),
    parameter logic [COLOR_W-1:0] CURSOR_BG    = COLOR_W'(CURSOR_BG_DEF),
    parameter logic [23:0]        BLINK_CYCLES = 24'd6000000,
    localparam int                IW           = idx_w(N_COLORS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               wr_ready,
    output logic               paint,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [COLOR_W-1:0] px_data,
    output logic [IW-1:0]      sel_idx,
    output logic               busy,
    output logic               cursor_paleta_done,
    output state_t             dbg_state
);

    localparam int SW = idx_w(BOX);

    if (N_COLORS < 2 || BOX < 2) begin : g_bad_size
        $error("cursor_paleta_gen: N_COLORS and BOX must both be at least 2");
    end
    if (PAL_X0 + N_COLORS * BOX > (1 << COORD_W) || PAL_Y0 + BOX > (1 << COORD_W)) begin : g_bad_fit
        $error("cursor_paleta_gen: palette row does not fit in COORD_W");
    end
    if (BLINK_CYCLES == 24'd0) begin : g_bad_blink
        $error("cursor_paleta_gen: BLINK_CYCLES must be non-zero");
    end

    state_t        state;
    logic [IW-1:0] prev_idx;
    logic          prev_valid;
    logic [IW-1:0] idx_moved;
    logic [IW-1:0] scan_idx;
    logic          start_req;
    logic          scan_start;
    logic          scan_en;
    logic          scan_last;
    logic [SW-1:0] nxt_ox;
    logic [SW-1:0] nxt_oy;
    logic          nxt_perim;

    function automatic logic [COORD_W-1:0] cell_x(input logic [IW-1:0] idx, input logic [SW-1:0] o);
        return COORD_W'(PAL_X0 + int'(idx) * BOX + int'(o));
    endfunction

    function automatic logic [COORD_W-1:0] cell_y(input logic [SW-1:0] o);
        return COORD_W'(PAL_Y0 + int'(o));
    endfunction

    always_comb begin
        idx_moved = sel_idx;
        if (move_left && !move_right)
            idx_moved = (sel_idx == '0) ? IW'(N_COLORS - 1) : sel_idx - 1'b1;
        else if (move_right && !move_left)
            idx_moved = (sel_idx == IW'(N_COLORS - 1)) ? '0 : sel_idx + 1'b1;
    end

`ifdef CURSOR_BLINK_EN
    logic [23:0] blink_cnt;
    logic        blink_phase;
    logic        blink_tick;
    logic        blink_draw;

    assign blink_tick = (blink_cnt == BLINK_CYCLES - 24'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_tick) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 24'd1;
        end
    end

    assign start_req = init || blink_tick;
`else
    assign start_req = init;
`endif

    // Valid/ready: paint is the valid; a pixel transfers on a cycle with paint && wr_ready,
    // px_x/px_y/px_data hold until then, and interior positions (paint=0) pass in one cycle.
    assign scan_idx   = (state == ERASE) ? prev_idx : sel_idx;
    assign scan_start = (state == IDLE) && start_req;
    assign scan_en    = ((state == ERASE) || (state == DRAW)) && (!paint || wr_ready);

    box_scan #(.BOX(BOX)) u_scan (
        .clk       (clk),
        .rst       (rst),
        .start     (scan_start),
        .en        (scan_en),
        .last      (scan_last),
        .nxt_ox    (nxt_ox),
        .nxt_oy    (nxt_oy),
        .nxt_perim (nxt_perim)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            sel_idx            <= '0;
            prev_idx           <= '0;
            prev_valid         <= 1'b0;
            paint              <= 1'b0;
            px_x               <= '0;
            px_y               <= '0;
            px_data            <= '0;
            busy               <= 1'b0;
            cursor_paleta_done <= 1'b0;
`ifdef CURSOR_BLINK_EN
            blink_draw         <= 1'b0;
`endif
        end else begin
            cursor_paleta_done <= 1'b0;
            case (state)
                IDLE: begin
                    sel_idx <= idx_moved;
                    if (init) begin
                        busy  <= 1'b1;
                        paint <= 1'b1;
                        px_y  <= cell_y('0);
`ifdef CURSOR_BLINK_EN
                        blink_draw <= 1'b0;
`endif
                        if (prev_valid && prev_idx != idx_moved) begin
                            state   <= ERASE;
                            px_x    <= cell_x(prev_idx, '0);
                            px_data <= CURSOR_BG;
                        end else begin
                            state   <= DRAW;
                            px_x    <= cell_x(idx_moved, '0);
                            px_data <= CURSOR_FG;
                        end
                    end
`ifdef CURSOR_BLINK_EN
                    // blink_phase flips on this same edge, so its new value is the inverse.
                    else if (blink_tick) begin
                        state      <= DRAW;
                        busy       <= 1'b1;
                        paint      <= 1'b1;
                        blink_draw <= 1'b1;
                        px_x       <= cell_x(idx_moved, '0);
                        px_y       <= cell_y('0);
                        px_data    <= blink_phase ? CURSOR_BG : CURSOR_FG;
                    end
`endif
                end
                ERASE, DRAW: begin
                    if (scan_en) begin
                        if (scan_last && state == ERASE) begin
                            state   <= DRAW;
                            paint   <= 1'b1;
                            px_x    <= cell_x(sel_idx, '0);
                            px_y    <= cell_y('0);
                            px_data <= CURSOR_FG;
                        end else if (scan_last) begin
                            state              <= DONE;
                            paint              <= 1'b0;
                            cursor_paleta_done <= 1'b1;
`ifdef CURSOR_BLINK_EN
                            if (!blink_draw) begin
                                prev_idx   <= sel_idx;
                                prev_valid <= 1'b1;
                            end
`else
                            prev_idx   <= sel_idx;
                            prev_valid <= 1'b1;
`endif
                        end else begin
                            paint <= nxt_perim;
                            px_x  <= cell_x(scan_idx, nxt_ox);
                            px_y  <= cell_y(nxt_oy);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_cursor_paleta_gen.sv
// Bench for cursor_paleta_gen: directed and randomized moves/redraws checked against a
// pixel-list model of the palette cursor built from the outline rules.
module tb_cursor_paleta_gen;

    localparam int N_COLORS = 8;
    localparam int COLOR_W  = 3;
    localparam int COORD_W  = 5;
    localparam int BOX      = 4;
    localparam int PAL_X0   = 0;
    localparam int PAL_Y0   = 28;
    localparam int PW       = 2 * COORD_W + COLOR_W;
    localparam logic [COLOR_W-1:0] FG = 3'b111;
    localparam logic [COLOR_W-1:0] BG = 3'b000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               init = 1'b0;
    logic               move_left = 1'b0;
    logic               move_right = 1'b0;
    logic               wr_ready = 1'b1;
    logic               paint;
    logic [COORD_W-1:0] px_x;
    logic [COORD_W-1:0] px_y;
    logic [COLOR_W-1:0] px_data;
    logic [2:0]         sel_idx;
    logic               busy;
    logic               cursor_paleta_done;
    logic [1:0]         dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_done = 0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] mon_e;
    int m_sel = 0;
    int m_prev = 0;
    bit m_prev_valid = 1'b0;

    cursor_paleta_gen #(
        .N_COLORS(N_COLORS), .COLOR_W(COLOR_W), .COORD_W(COORD_W), .BOX(BOX),
        .PAL_X0(PAL_X0), .PAL_Y0(PAL_Y0), .CURSOR_FG(FG), .CURSOR_BG(BG),
        .BLINK_CYCLES(24'd40)
    ) dut (
        .clk(clk), .rst(rst), .init(init), .move_left(move_left), .move_right(move_right),
        .wr_ready(wr_ready), .paint(paint), .px_x(px_x), .px_y(px_y), .px_data(px_data),
        .sel_idx(sel_idx), .busy(busy), .cursor_paleta_done(cursor_paleta_done),
        .dbg_state(dbg_state)
    );

    // Clock / reset-independent cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference model
    function automatic void model_move(input bit l, input bit r);
        if (l && !r) m_sel = (m_sel + N_COLORS - 1) % N_COLORS;
        else if (r && !l) m_sel = (m_sel + 1) % N_COLORS;
    endfunction

    function automatic void push_box(input int idx, input logic [COLOR_W-1:0] d);
        for (int oy = 0; oy < BOX; oy++)
            for (int ox = 0; ox < BOX; ox++)
                if (ox == 0 || oy == 0 || ox == BOX - 1 || oy == BOX - 1)
                    exp_q.push_back({COORD_W'(PAL_X0 + idx * BOX + ox), COORD_W'(PAL_Y0 + oy), d});
    endfunction

    function automatic int model_redraw();
        int n;
        n = BOX * BOX;
        if (m_prev_valid && m_prev != m_sel) begin
            push_box(m_prev, BG);
            n += BOX * BOX;
        end
        push_box(m_sel, FG);
        m_prev = m_sel;
        m_prev_valid = 1'b1;
        return n;
    endfunction

    // Scoreboard: every transferred pixel must be the next one the model expects
    always @(negedge clk) begin
        if (rst && paint && wr_ready) begin
            vectors++;
            assert (exp_q.size() > 0) else begin
                miscompares++;
                $error("FAIL extra_pixel: observed x=%0d y=%0d d=%0d expected no pixel", px_x, px_y, px_data);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                assert ({px_x, px_y, px_data} === mon_e) else begin
                    miscompares++;
                    $error("FAIL pixel: observed x=%0d y=%0d d=%0d expected x=%0d y=%0d d=%0d",
                           px_x, px_y, px_data, mon_e[PW-1 -: COORD_W],
                           mon_e[COLOR_W +: COORD_W], mon_e[COLOR_W-1:0]);
                end
            end
        end
        if (rst && cursor_paleta_done) n_done++;
    end

    // Driver tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input bit l, input bit r, input string tag);
        move_left = l;
        move_right = r;
        tick();
        move_left = 1'b0;
        move_right = 1'b0;
        model_move(l, r);
        check(tag, 32'(sel_idx), 32'(m_sel));
    endtask

    task automatic start_init(input bit l, input bit r, output int t_acc, output int n_pos);
        init = 1'b1;
        move_left = l;
        move_right = r;
        model_move(l, r);
        n_pos = model_redraw();
        tick();
        t_acc = cyc;
        init = 1'b0;
        move_left = 1'b0;
        move_right = 1'b0;
    endtask

    // mode 0: wr_ready high; 1: random wr_ready; 2: wr_ready low for stall_n cycles first
    task automatic wait_done(input int mode, input int stall_n, input int budget, output int done_cyc);
        bit seen;
        seen = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < budget && !seen; k++) begin
            case (mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = ($urandom_range(0, 3) != 0);
                default: wr_ready = (k >= stall_n);
            endcase
            @(negedge clk);
            if (mode == 2 && k < stall_n && exp_q.size() > 0)
                check("stall_hold", 32'({paint, px_x, px_y, px_data}), 32'({1'b1, exp_q[0]}));
            if (cursor_paleta_done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
            tick();
        end
        wr_ready = 1'b1;
    endtask

    task automatic redraw(input bit l, input bit r, input int mode, input int stall_n,
                          input bit poke, input string tag);
        int t, n, dc;
        start_init(l, r, t, n);
        if (poke) begin
            move_right = 1'b1;
            init = 1'b1;
        end
        wait_done(mode, stall_n, 300, dc);
        move_right = 1'b0;
        init = 1'b0;
        if (mode == 1) check({tag, "_done_seen"}, 32'(dc >= 0), 32'd1);
        else check({tag, "_done_cycle"}, 32'(dc), 32'(t + n + stall_n));
        check({tag, "_pixels_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check({tag, "_idle_after"}, 32'({busy, cursor_paleta_done}), 32'd0);
        check({tag, "_sel_idx"}, 32'(sel_idx), 32'(m_sel));
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_paint", 32'(paint), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(cursor_paleta_done), 32'd0);
        check("reset_px_x", 32'(px_x), 32'd0);
        check("reset_px_y", 32'(px_y), 32'd0);
        check("reset_px_data", 32'(px_data), 32'd0);
        check("reset_sel_idx", 32'(sel_idx), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        tick();

`ifdef CURSOR_BLINK_EN
        n_done = 0;
        push_box(0, FG);
        push_box(0, BG);
        repeat (110) tick();
        check("blink_done_count", 32'(n_done), 32'd2);
        check("blink_pixels_left", 32'(exp_q.size()), 32'd0);
        check("blink_sel_idx", 32'(sel_idx), 32'd0);
        exp_q.delete();
`else
        // First draw at cell 0, then move two cells right and redraw with erase
        redraw(1'b0, 1'b0, 0, 0, 1'b0, "first_draw");
        do_move(1'b0, 1'b1, "move_right_1");
        do_move(1'b0, 1'b1, "move_right_2");
        redraw(1'b0, 1'b0, 0, 0, 1'b0, "erase_draw");

        // Wrap-around and simultaneous moves
        do_move(1'b1, 1'b0, "move_left_1");
        do_move(1'b1, 1'b0, "move_left_2");
        do_move(1'b1, 1'b0, "wrap_left");
        do_move(1'b0, 1'b1, "wrap_right");
        do_move(1'b1, 1'b1, "both_moves");

        // Erase back to cell 0, then a stalled draw-only redraw with inputs poked while busy
        redraw(1'b0, 1'b0, 0, 0, 1'b0, "erase_back");
        redraw(1'b0, 1'b0, 2, 5, 1'b1, "stall_draw");

        // Reset in the middle of a draw
        begin
            int t, n;
            start_init(1'b0, 1'b0, t, n);
            repeat (7) tick();
            rst = 1'b0;
            #1;
            check("midreset_paint", 32'(paint), 32'd0);
            check("midreset_busy", 32'(busy), 32'd0);
            check("midreset_state", 32'(dbg_state), 32'd0);
            exp_q.delete();
            m_sel = 0;
            m_prev = 0;
            m_prev_valid = 1'b0;
            tick();
            rst = 1'b1;
            tick();
        end
        do_move(1'b0, 1'b1, "post_reset_move");
        redraw(1'b0, 1'b0, 0, 0, 1'b0, "post_reset_draw");

        // Randomized moves and redraws with random back-pressure
        for (int i = 0; i < 12; i++) begin
            int nm;
            nm = $urandom_range(0, 3);
            for (int j = 0; j < nm; j++)
                do_move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_move");
            redraw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 1'b0, "rand_redraw");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
